kbd_uart_mmio: RTL and testbench

Memory-mapped console peripheral on the CPU data bus. It replaces the hard-wired keyboard-to-UART path with two things:
- a parametrised keyboard RX FIFO, read by the CPU through registers;
- a parametrised TX FIFO that drains into the JTAG UART Avalon slave under waitrequest flow control.

It also provides status/control registers and a level interrupt for the future interrupt controller.

---
 rtl/kbd_uart_mmio.sv | 138 +++++++++++++
 tb/tb_kbd_uart_mmio.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/kbd_uart_mmio.sv
// kbd_uart_mmio: bus-mapped console with a keyboard RX FIFO, a TX FIFO draining
// into the JTAG UART Avalon slave, status/control registers and a level irq.
module kbd_uart_mmio #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 64'h8000_0000,
    parameter int RX_DEPTH = 16,
    parameter int TX_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] bus_address,
    input  logic [DATA_WIDTH-1:0] bus_write_data,
    input  logic                  bus_write_enable,
    input  logic                  bus_read_enable,
    output logic [DATA_WIDTH-1:0] bus_read_data,
    input  logic [7:0]            kbd_ascii,
    input  logic                  kbd_pressed,
    output logic                  irq,
    output logic                  uart_address,
    output logic [31:0]           uart_writedata,
    output logic                  uart_write_n,
    input  logic                  uart_waitrequest
);
    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);

    typedef enum logic {IDLE, WRITE} state_t;

    logic                sel;
    logic [1:0]          off;
    logic                ctrl_wr;
    logic                unused;
    logic [7:0]          rx_mem [RX_DEPTH];
    logic [RAW-1:0]      rx_rd, rx_wr;
    logic [RAW:0]        rx_cnt;
    logic                kbd_prev, rx_push, rx_pop, rx_acc, rx_full, rx_empty;
    logic [7:0]          tx_mem [TX_DEPTH];
    logic [TAW-1:0]      tx_rd, tx_wr;
    logic [TAW:0]        tx_cnt;
    logic                tx_push, tx_pop, tx_acc, tx_full, tx_empty;
    logic                rx_overflow, tx_drop, rx_irq_en;
    logic [31:0]         status, rd_mux;
    state_t              state, state_next;

    assign sel      = bus_address[ADDR_WIDTH-1:5] == BASE_ADDR[ADDR_WIDTH-1:5];
    assign off      = bus_address[4:3];
    assign ctrl_wr  = sel & bus_write_enable & (off == 2'd3);
    assign unused   = ^{bus_address[2:0], bus_write_data[DATA_WIDTH-1:8]};

    assign rx_push  = kbd_pressed & ~kbd_prev;
    assign rx_empty = rx_cnt == '0;
    assign rx_full  = rx_cnt == (RAW+1)'(RX_DEPTH);
    assign rx_pop   = sel & bus_read_enable & (off == 2'd0) & ~rx_empty;
    assign rx_acc   = rx_push & (~rx_full | rx_pop);

    assign tx_push  = sel & bus_write_enable & (off == 2'd2);
    assign tx_empty = tx_cnt == '0;
    assign tx_full  = tx_cnt == (TAW+1)'(TX_DEPTH);
    assign tx_acc   = tx_push & (~tx_full | tx_pop);

    assign uart_address = 1'b0;

    always_ff @(posedge clk) begin
        if (rx_acc)
            rx_mem[rx_wr] <= kbd_ascii;
        if (tx_acc)
            tx_mem[tx_wr] <= bus_write_data[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kbd_prev <= 1'b0;
            rx_rd    <= '0;
            rx_wr    <= '0;
            rx_cnt   <= '0;
            tx_rd    <= '0;
            tx_wr    <= '0;
            tx_cnt   <= '0;
        end else begin
            kbd_prev <= kbd_pressed;
            rx_wr    <= rx_acc ? rx_wr + 1'b1 : rx_wr;
            rx_rd    <= rx_pop ? rx_rd + 1'b1 : rx_rd;
            rx_cnt   <= rx_cnt + (RAW+1)'(rx_acc) - (RAW+1)'(rx_pop);
            tx_wr    <= tx_acc ? tx_wr + 1'b1 : tx_wr;
            tx_rd    <= tx_pop ? tx_rd + 1'b1 : tx_rd;
            tx_cnt   <= tx_cnt + (TAW+1)'(tx_acc) - (TAW+1)'(tx_pop);
        end
    end

    // A sticky set in the same cycle as a CTRL clear must survive.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overflow <= 1'b0;
            tx_drop     <= 1'b0;
            rx_irq_en   <= 1'b0;
            irq         <= 1'b0;
        end else begin
            rx_overflow <= (rx_push & rx_full & ~rx_pop) | (rx_overflow & ~(ctrl_wr & bus_write_data[1]));
            tx_drop     <= (tx_push & tx_full & ~tx_pop) | (tx_drop & ~(ctrl_wr & bus_write_data[1]));
            rx_irq_en   <= ctrl_wr ? bus_write_data[0] : rx_irq_en;
            irq         <= rx_irq_en & ~rx_empty;
        end
    end

    always_comb begin
        status = {8'(tx_cnt), 8'(rx_cnt), 9'b0, rx_irq_en, tx_drop, rx_overflow,
                  tx_full, tx_empty, rx_full, ~rx_empty};
        rd_mux = !sel         ? 32'd0 :
                 off == 2'd0  ? (rx_empty ? 32'd0 : {24'd0, rx_mem[rx_rd]}) :
                 off == 2'd1  ? status :
                 off == 2'd3  ? {31'd0, rx_irq_en} : 32'd0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            bus_read_data <= '0;
        else if (bus_read_enable)
            bus_read_data <= DATA_WIDTH'(rd_mux);
    end

    always_comb begin
        tx_pop     = (state == IDLE) & ~tx_empty;
        state_next = tx_pop ? WRITE : (state == WRITE && uart_waitrequest) ? WRITE : IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            uart_write_n   <= 1'b1;
            uart_writedata <= '0;
        end else begin
            state          <= state_next;
            uart_write_n   <= state_next != WRITE;
            uart_writedata <= tx_pop ? {24'd0, tx_mem[tx_rd]} : uart_writedata;
        end
    end
endmodule

// File: tb/tb_kbd_uart_mmio.sv
// tb_kbd_uart_mmio: randomized scoreboard bench; a queue-based model predicts
// read data, UART bytes, irq and Avalon signalling for kbd_uart_mmio.
module tb_kbd_uart_mmio;
    localparam int RXD = 16;
    localparam int TXD = 16;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] bus_address, bus_write_data, bus_read_data;
    logic        bus_write_enable, bus_read_enable;
    logic [7:0]  kbd_ascii;
    logic        kbd_pressed, irq, uart_address, uart_write_n, uart_waitrequest;
    logic [31:0] uart_writedata;

    int checks = 0;
    int failures = 0;

    logic [7:0]  rx_q[$], tx_q[$], uart_q[$];
    logic [63:0] rd_q[$];
    bit          m_kprev, m_busy, m_ien, m_ovf, m_drop, m_irq;
    logic [7:0]  m_cur;

    kbd_uart_mmio #(.ADDR_WIDTH(64), .DATA_WIDTH(64), .BASE_ADDR(BASE),
                    .RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk(clk), .reset(reset), .bus_address(bus_address),
        .bus_write_data(bus_write_data), .bus_write_enable(bus_write_enable),
        .bus_read_enable(bus_read_enable), .bus_read_data(bus_read_data),
        .kbd_ascii(kbd_ascii), .kbd_pressed(kbd_pressed), .irq(irq),
        .uart_address(uart_address), .uart_writedata(uart_writedata),
        .uart_write_n(uart_write_n), .uart_waitrequest(uart_waitrequest)
    );

    always #5 clk = ~clk;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] status();
        int rc = rx_q.size();
        int tc = tx_q.size();
        return (64'(tc) << 24) | (64'(rc) << 16) | (64'(m_ien) << 6) | (64'(m_drop) << 5) |
               (64'(m_ovf) << 4) | (64'(tc == TXD) << 3) | (64'(tc == 0) << 2) |
               (64'(rc == RXD) << 1) | 64'(rc != 0);
    endfunction

    // Predicts the effect of the coming clock edge from the inputs now driven.
    task automatic model_step();
        bit sel, txpush, txpop, done, nirq;
        int off;
        logic [63:0] rv;
        if (reset) begin
            if (bus_read_enable) rd_q.push_back(64'd0);
            rx_q.delete(); tx_q.delete(); uart_q.delete();
            m_kprev = 0; m_busy = 0; m_ien = 0; m_ovf = 0; m_drop = 0; m_irq = 0; m_cur = 0;
            return;
        end
        sel  = (bus_address >> 5) == (BASE >> 5);
        off  = int'(bus_address[4:3]);
        nirq = m_ien && rx_q.size() > 0;
        if (bus_read_enable) begin
            rv = 0;
            if (sel && off == 0 && rx_q.size() > 0) rv = 64'(rx_q.pop_front());
            else if (sel && off == 1) rv = status();
            else if (sel && off == 3) rv = 64'(m_ien);
            rd_q.push_back(rv);
        end
        if (sel && bus_write_enable && off == 3) begin
            m_ien = bus_write_data[0];
            if (bus_write_data[1]) begin m_ovf = 0; m_drop = 0; end
        end
        if (kbd_pressed && !m_kprev) begin
            if (rx_q.size() < RXD) rx_q.push_back(kbd_ascii);
            else m_ovf = 1;
        end
        m_kprev = kbd_pressed;
        txpush = sel && bus_write_enable && off == 2;
        txpop  = !m_busy && tx_q.size() > 0;
        done   = m_busy && !uart_waitrequest;
        if (txpop) m_cur = tx_q.pop_front();
        if (txpush) begin
            if (tx_q.size() < TXD) begin
                tx_q.push_back(bus_write_data[7:0]);
                uart_q.push_back(bus_write_data[7:0]);
            end else m_drop = 1;
        end
        if (txpop) m_busy = 1;
        else if (done) m_busy = 0;
        m_irq = nirq;
    endtask

    task automatic step();
        model_step();
        @(negedge clk);
        #1;
        bus_write_enable = 0;
        bus_read_enable  = 0;
    endtask

    task automatic rd(int off);
        bus_address = BASE + 64'(off * 8);
        bus_read_enable = 1;
        step();
    endtask

    task automatic wr(int off, logic [63:0] d);
        bus_address = BASE + 64'(off * 8);
        bus_write_data = d;
        bus_write_enable = 1;
        step();
    endtask

    task automatic key(logic [7:0] c);
        kbd_ascii = c;
        kbd_pressed = 1;
        step();
        kbd_pressed = 0;
        step();
    endtask

    // Monitor: outputs at a falling edge reflect the preceding rising edge.
    initial begin
        logic        pwn = 1'b1;
        logic [31:0] pwd = 32'd0;
        forever begin
            @(negedge clk);
            if (bus_read_enable) begin
                if (rd_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL read_unexpected: got %h expected none", bus_read_data);
                end else chk("read_data", bus_read_data, rd_q.pop_front());
            end
            if (!reset && !pwn && !uart_waitrequest) begin
                if (uart_q.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL uart_unexpected: got %h expected none", pwd);
                end else chk("uart_byte", 64'(pwd), 64'(uart_q.pop_front()));
            end
            chk("uart_write_n", 64'(uart_write_n), 64'(!m_busy));
            chk("uart_writedata", 64'(uart_writedata), 64'(m_cur));
            chk("irq", 64'(irq), 64'(m_irq));
            chk("uart_address", 64'(uart_address), 64'd0);
            pwn = uart_write_n;
            pwd = uart_writedata;
        end
    end

    initial begin
        reset = 1; bus_address = BASE; bus_write_data = 0; bus_write_enable = 0;
        bus_read_enable = 0; kbd_ascii = 0; kbd_pressed = 0; uart_waitrequest = 0;
        step();
        step();
        reset = 0;
        chk("reset_read_data", bus_read_data, 64'd0);
        chk("reset_write_n", 64'(uart_write_n), 64'd1);
        chk("reset_writedata", 64'(uart_writedata), 64'd0);
        chk("reset_irq", 64'(irq), 64'd0);
        rd(1);
        kbd_ascii = 8'h41; kbd_pressed = 1;
        repeat (5) step();
        kbd_pressed = 0;
        step();
        rd(1); rd(0); rd(1); rd(0);
        for (int i = 0; i < 17; i++) key(8'h61 + 8'(i));
        rd(1);
        repeat (16) rd(0);
        rd(1); wr(3, 64'h2); rd(1);
        uart_waitrequest = 1;
        wr(2, 64'h48); wr(2, 64'h69);
        repeat (3) step();
        uart_waitrequest = 0;
        repeat (8) step();
        rd(1);
        wr(3, 64'h1); key(8'h0D); step(); rd(0); repeat (3) step();
        uart_waitrequest = 1;
        wr(2, 64'h55);
        repeat (2) step();
        reset = 1;
        rd(1);
        reset = 0; uart_waitrequest = 0;
        repeat (10) step();
        rd(1);
        for (int n = 0; n < 3000; n++) begin
            int r = $urandom_range(0, 99);
            int off = $urandom_range(0, 3);
            logic [63:0] a = BASE + 64'(off * 8) + 64'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = a ^ (64'h20 << $urandom_range(0, 20));
            if ($urandom_range(0, 3) == 0) kbd_pressed = ~kbd_pressed;
            kbd_ascii = 8'($urandom);
            uart_waitrequest = $urandom_range(0, 2) != 0;
            reset = $urandom_range(0, 299) == 0;
            bus_address = a;
            if (r < 30) bus_read_enable = 1;
            else if (r < 55) begin
                bus_write_enable = 1;
                bus_write_data = (off == 3) ? ($urandom_range(0, 1) ? 64'h3 : 64'h1) : {$urandom, $urandom};
            end
            step();
        end
        reset = 0; kbd_pressed = 0; uart_waitrequest = 0;
        repeat (3 * TXD + 10) step();
        chk("uart_drained", 64'(uart_q.size()), 64'd0);
        chk("reads_drained", 64'(rd_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
